// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory port between instruction fetch and load/store
// Load/store wins arbitration unless fetch has lost STARVE_LIMIT times in a row.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int WCW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_LOAD  = WCW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              owner_q;          // 1 = load/store owns the bus
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [SCW-1:0]    starve_q;
  logic [WCW-1:0]    wait_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  logic              grant_if, grant_ls, capture;

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req && !(if_req && starve_q == STARVE_MAX)) grant_ls = 1'b1;
        else if (if_req)                                   grant_if = 1'b1;
        if (grant_if || grant_ls) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (MEM_LATENCY == 0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      starve_q   <= '0;
      wait_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant_if || grant_ls) begin
        owner_q <= grant_ls;
        addr_q  <= grant_ls ? ls_addr : if_addr;
        we_q    <= grant_ls && ls_we;
        wdata_q <= grant_ls ? ls_wdata : '0;
      end
      // Only a lost contention counts towards starvation; an uncontested ls grant leaves it alone.
      if (grant_if)
        starve_q <= '0;
      else if (grant_ls && if_req && starve_q != STARVE_MAX)
        starve_q <= starve_q + 1'b1;
      if (state == ACCESS)
        wait_q <= WAIT_LOAD;
      else if (state == WAIT && wait_q != '0)
        wait_q <= wait_q - 1'b1;
      if (capture && !we_q) begin
        if (owner_q) ls_rdata_q <= mem_rdata;
        else         if_rdata_q <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == ACCESS) || (state == WAIT);
  assign mem_we    = (state == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_gnt    = busy && !owner_q;
  assign ls_gnt    = busy && owner_q;
  assign if_done   = (state == DONE) && !owner_q;
  assign ls_done   = (state == DONE) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int L  = 2;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [31:0] rdata_force = '0;
  logic        use_hash = 1'b0;

  logic        if_gnt0, if_done0, ls_gnt0, ls_done0, mem_en0, mem_we0, busy0;
  logic [31:0] if_rdata0, ls_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        if_gnt1, if_done1, ls_gnt1, ls_done1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A0F0F;
  endfunction

  assign mem_rdata0 = use_hash ? hash(mem_addr0) : rdata_force;
  assign mem_rdata1 = use_hash ? hash(mem_addr1) : rdata_force;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0), .if_rdata(if_rdata0), .if_done(if_done0),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt0), .ls_rdata(ls_rdata0), .ls_done(ls_done0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(0), .STARVE_LIMIT(SL)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rdata(if_rdata1), .if_done(if_done1),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt1), .ls_rdata(ls_rdata1), .ls_done(ls_done1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // flags = {busy, mem_en, mem_we, if_gnt, if_done, ls_gnt, ls_done}
  typedef struct {
    logic        rst, ifr, lsr, we;
    logic [31:0] ia, la, wd, rd;
    logic [6:0]  flags;
    logic [31:0] maddr, mwdata, ird, lrd;
  } vec_t;

  function automatic vec_t mk(logic rst, logic ifr, logic lsr, logic we,
                              logic [31:0] ia, logic [31:0] la, logic [31:0] wd, logic [31:0] rd,
                              logic [6:0] flags, logic [31:0] maddr, logic [31:0] mwdata,
                              logic [31:0] ird, logic [31:0] lrd);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.lsr = lsr; v.we = we;
    v.ia = ia; v.la = la; v.wd = wd; v.rd = rd;
    v.flags = flags; v.maddr = maddr; v.mwdata = mwdata; v.ird = ird; v.lrd = lrd;
    return v;
  endfunction

  vec_t vecs[16];

  // transaction-level reference: k counts cycles since the grant (0 = no transaction)
  int          k, m_starve;
  logic        m_owner, m_we;
  logic [31:0] m_addr, m_ird, m_lrd;

  logic [6:0]  f_act, f_exp;
  logic [7:0]  order;
  int          cnt, ngr, overlap, en_cyc, bad, seen;
  logic        prev_ig, prev_lg;
  logic        pick_ls;

  initial begin
    // single fetch, load, then store (store must leave ls_rdata alone)
    vecs[0]  = mk(0,0,0,0, 0,     0,     0,            0,            7'b0000000, 0,     0,            0,            0);
    vecs[1]  = mk(1,1,0,0, 'h100, 0,     0,            'hE1A00000,   7'b1101000, 'h100, 0,            0,            0);
    vecs[2]  = mk(1,1,0,0, 'h100, 0,     0,            'hE1A00000,   7'b1101000, 'h100, 0,            0,            0);
    vecs[3]  = mk(1,1,0,0, 'h100, 0,     0,            'hE1A00000,   7'b1101000, 'h100, 0,            0,            0);
    vecs[4]  = mk(1,1,0,0, 'h100, 0,     0,            'hE1A00000,   7'b1001100, 'h100, 0,            'hE1A00000,   0);
    vecs[5]  = mk(1,0,0,0, 'h100, 0,     0,            'hE1A00000,   7'b0000000, 'h100, 0,            'hE1A00000,   0);
    vecs[6]  = mk(1,0,1,0, 'h100, 'h80,  0,            'hCAFEF00D,   7'b1100010, 'h80,  0,            'hE1A00000,   0);
    vecs[7]  = mk(1,0,1,0, 'h100, 'h80,  0,            'hCAFEF00D,   7'b1100010, 'h80,  0,            'hE1A00000,   0);
    vecs[8]  = mk(1,0,1,0, 'h100, 'h80,  0,            'hCAFEF00D,   7'b1100010, 'h80,  0,            'hE1A00000,   0);
    vecs[9]  = mk(1,0,1,0, 'h100, 'h80,  0,            'hCAFEF00D,   7'b1000011, 'h80,  0,            'hE1A00000,   'hCAFEF00D);
    vecs[10] = mk(1,0,0,0, 'h100, 'h80,  0,            'hCAFEF00D,   7'b0000000, 'h80,  0,            'hE1A00000,   'hCAFEF00D);
    vecs[11] = mk(1,0,1,1, 'h100, 'h200, 'hDEADBEEF,   'h11111111,   7'b1110010, 'h200, 'hDEADBEEF,   'hE1A00000,   'hCAFEF00D);
    vecs[12] = mk(1,0,1,1, 'h100, 'h200, 'hDEADBEEF,   'h11111111,   7'b1100010, 'h200, 'hDEADBEEF,   'hE1A00000,   'hCAFEF00D);
    vecs[13] = mk(1,0,1,1, 'h100, 'h200, 'hDEADBEEF,   'h11111111,   7'b1100010, 'h200, 'hDEADBEEF,   'hE1A00000,   'hCAFEF00D);
    vecs[14] = mk(1,0,1,1, 'h100, 'h200, 'hDEADBEEF,   'h11111111,   7'b1000011, 'h200, 'hDEADBEEF,   'hE1A00000,   'hCAFEF00D);
    vecs[15] = mk(1,0,0,0, 'h100, 'h200, 'hDEADBEEF,   'h11111111,   7'b0000000, 'h200, 'hDEADBEEF,   'hE1A00000,   'hCAFEF00D);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; if_req = vecs[i].ifr; ls_req = vecs[i].lsr; ls_we = vecs[i].we;
      if_addr = vecs[i].ia; ls_addr = vecs[i].la; ls_wdata = vecs[i].wd; rdata_force = vecs[i].rd;
      @(posedge clk); #1;
      f_act = {busy0, mem_en0, mem_we0, if_gnt0, if_done0, ls_gnt0, ls_done0};
      check($sformatf("vec%0d flags", i), 64'(f_act), 64'(vecs[i].flags));
      check($sformatf("vec%0d mem_addr", i), 64'(mem_addr0), 64'(vecs[i].maddr));
      check($sformatf("vec%0d mem_wdata", i), 64'(mem_wdata0), 64'(vecs[i].mwdata));
      check($sformatf("vec%0d if_rdata", i), 64'(if_rdata0), 64'(vecs[i].ird));
      check($sformatf("vec%0d ls_rdata", i), 64'(ls_rdata0), 64'(vecs[i].lrd));
    end

    // contention: both held high, fetch must win every fourth grant
    do_reset();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; if_addr = 'h10; ls_addr = 'h20;
    ngr = 0; order = '0; overlap = 0; cnt = 0; prev_ig = 1'b0; prev_lg = 1'b0;
    while (ngr < 8 && cnt < 100) begin
      @(posedge clk); #1; cnt++;
      if (if_gnt0 && ls_gnt0) overlap++;
      if (if_done0 && ls_done0) overlap++;
      if (if_gnt0 && !prev_ig) begin order = {order[6:0], 1'b0}; ngr++; end
      if (ls_gnt0 && !prev_lg) begin order = {order[6:0], 1'b1}; ngr++; end
      prev_ig = if_gnt0; prev_lg = ls_gnt0;
    end
    check("contention grants", 64'(ngr), 64'd8);
    check("contention order", 64'(order), 64'hEE);
    check("contention overlap", 64'(overlap), 64'd0);
    @(negedge clk); if_req = 1'b0; ls_req = 1'b0;

    // zero-latency load
    do_reset();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 'h40; rdata_force = 'h12345678;
    cnt = 0; en_cyc = 0;
    while (!ls_done1 && cnt < 10) begin
      @(posedge clk); #1; cnt++;
      if (mem_en1) en_cyc++;
    end
    check("lat0 done cycles", 64'(cnt), 64'd2);
    check("lat0 mem_en cycles", 64'(en_cyc), 64'd1);
    check("lat0 ls_rdata", 64'(ls_rdata1), 64'h12345678);
    @(negedge clk); ls_req = 1'b0;

    // asynchronous reset in the middle of a fetch WAIT
    do_reset();
    if_req = 1'b1; if_addr = 'h500; rdata_force = 'hA5A5A5A5;
    @(posedge clk); @(posedge clk); #3;
    check("wait busy before reset", 64'({busy0, mem_en0, if_gnt0}), 64'b111);
    reset = 1'b0; #1;
    check("async reset outputs", 64'({busy0, mem_en0, mem_we0, if_gnt0, if_done0, mem_addr0}), 64'd0);
    @(negedge clk); if_req = 1'b0; reset = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (if_done0 || busy0) seen++; end
    check("no done after abort", 64'(seen), 64'd0);
    @(negedge clk); if_req = 1'b1;
    cnt = 0;
    while (!if_done0 && cnt < 10) begin @(posedge clk); #1; cnt++; end
    check("refetch latency", 64'(cnt), 64'd4);
    check("refetch if_rdata", 64'(if_rdata0), 64'hA5A5A5A5);
    @(negedge clk); if_req = 1'b0;

    // address changed after grant must not reach the memory
    do_reset();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 'h300;
    cnt = 0; en_cyc = 0; bad = 0;
    while (!ls_done0 && cnt < 10) begin
      @(posedge clk); #1; cnt++;
      if (mem_en0) begin en_cyc++; if (mem_addr0 !== 32'h300) bad++; end
      ls_addr = 'h304;
    end
    check("addr hold done cycles", 64'(cnt), 64'd4);
    check("addr hold mem_en cycles", 64'(en_cyc), 64'd3);
    check("addr hold mem_addr", 64'(bad), 64'd0);
    @(negedge clk); ls_req = 1'b0;

    // randomized traffic against the transaction-level model
    do_reset();
    use_hash = 1'b1;
    k = 0; m_starve = 0; m_owner = 1'b0; m_we = 1'b0; m_addr = '0; m_ird = '0; m_lrd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      f_exp = {k != 0, k >= 1 && k <= L + 1, k == 1 && m_we,
               k != 0 && !m_owner, k == L + 2 && !m_owner,
               k != 0 && m_owner,  k == L + 2 && m_owner};
      f_act = {busy0, mem_en0, mem_we0, if_gnt0, if_done0, ls_gnt0, ls_done0};
      check("rand flags", 64'(f_act), 64'(f_exp));
      check("rand if_rdata", 64'(if_rdata0), 64'(m_ird));
      check("rand ls_rdata", 64'(ls_rdata0), 64'(m_lrd));
      if (k >= 1 && k <= L + 1) check("rand mem_addr", 64'(mem_addr0), 64'(m_addr));
      // requesters: drop on done, otherwise raise at random and scramble addresses while waiting
      if (k == L + 2 && !m_owner) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) != 0) begin if_req = 1'b1; if_addr = $urandom; end
      else if (if_req && $urandom_range(0, 3) == 0) if_addr = $urandom;
      if (k == L + 2 && m_owner) ls_req = 1'b0;
      else if (!ls_req && $urandom_range(0, 2) != 0) begin
        ls_req = 1'b1; ls_addr = $urandom; ls_we = 1'($urandom_range(0, 1));
      end
      else if (ls_req && $urandom_range(0, 3) == 0) ls_addr = $urandom;
      ls_wdata = $urandom;
      @(posedge clk);
      if (k == 0) begin
        if (if_req || ls_req) begin
          pick_ls = ls_req && !(if_req && m_starve == SL);
          if (!pick_ls) m_starve = 0;
          else if (if_req && m_starve < SL) m_starve++;
          m_owner = pick_ls;
          m_addr  = pick_ls ? ls_addr : if_addr;
          m_we    = pick_ls && ls_we;
          k = 1;
        end
      end else if (k == L + 2) begin
        k = 0;
      end else begin
        if (k == L + 1 && !m_we) begin
          if (m_owner) m_lrd = hash(m_addr);
          else         m_ird = hash(m_addr);
        end
        k++;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port between the instruction-fetch path and the load/store path of the CPU.
- Uses a req/gnt/done handshake with fixed wait-state sequencing for the memory latency.
- Priority goes to load/store, with a starvation guard so fetch is not locked out.
- Sits between logic_control / address register and the memory; replaces direct PC-to-memory wiring.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, wait cycles after the access cycle before mem_rdata is valid (0 allowed).
- STARVE_LIMIT, 3, consecutive fetch losses after which fetch wins the next arbitration (≥1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held high until if_done
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch owns the bus (high ACCESS..DONE)
- if_rdata  out  DATA_W  fetched word, valid when if_done
- if_done  out  1  one-cycle completion pulse for fetch
- ls_req  in  1  load/store request, held high until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  load/store owns the bus
- ls_rdata  out  DATA_W  loaded word, valid when ls_done
- ls_done  out  1  one-cycle completion pulse for load/store
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, any time, asynchronous): state IDLE, all outputs 0, starve counter 0, wait counter 0, latched addr/wdata/we/owner 0. An in-flight transaction is aborted: no done pulse, no mem_we.
- All outputs are registered or decoded from registered state only. No combinational path from req to outputs.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: arbitrate on sampled if_req/ls_req.
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant ls, unless starve_cnt == STARVE_LIMIT, in which case grant if.
  - On grant: latch owner, addr, we (fetch forces we=0) and wdata. Go to ACCESS.
- ACCESS (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values. The owner's gnt is 1.
  - MEM_LATENCY=0: sample mem_rdata at the exit edge, go to DONE.
  - Otherwise: load wait counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: mem_en=1, mem_we=0, mem_addr held.
  - Counter decrements each cycle.
  - At counter==0: sample mem_rdata into the owner's rdata register and go to DONE.
- DONE (1 cycle): owner's done=1, gnt still 1, mem_en=0. Always go to IDLE next.
- Transaction latency: req seen in IDLE → done high exactly MEM_LATENCY+2 cycles later. Minimum spacing between grants is MEM_LATENCY+3 cycles.
- Requester rule: deassert req on the edge that samples done=1. A req still high in IDLE is treated as a new request.
- A req dropped mid-transaction is ignored; the transaction completes and done still pulses.
- Changing addr/wdata after grant has no effect, because the values are latched.
- rdata registers hold their value until that owner's next read completes. Stores leave rdata unchanged.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, when both requests are seen in IDLE and ls wins.
  - Clears when if is granted.
  - Unchanged otherwise.
- gnt and done are never high for both requesters at once.
- busy = (state != IDLE).

Test Plan:
- Reset then single fetch: if_req=1, if_addr=0x100, mem_rdata=0xE1A00000, MEM_LATENCY=2 → mem_en high 3 cycles with mem_addr=0x100, mem_we=0; if_done one pulse 4 cycles after req seen; if_rdata=0xE1A00000; ls_* stay 0.
- Store: ls_req=1, ls_we=1, ls_addr=0x200, ls_wdata=0xDEADBEEF → mem_we=1 only in the ACCESS cycle with 0x200/0xDEADBEEF; ls_done pulses; ls_rdata unchanged.
- Contention with STARVE_LIMIT=3: if_req and ls_req held continuously (ls re-requesting every IDLE) → grant order ls, ls, ls, if, ls, ls, ls, if…; no overlap of gnt/done.
- MEM_LATENCY=0 load from 0x40 returning 0x12345678 → ACCESS→DONE; ls_done 2 cycles after req; ls_rdata=0x12345678.
- Reset asserted (reset=0) during WAIT of a fetch → outputs 0 immediately (asynchronous); after release no if_done pulse; a new if_req completes normally.
- Address change after grant: ls_addr switches 0x300→0x304 during WAIT → mem_addr stays 0x300 for the whole transaction.
